// File: rtl/router_ingress_port_pkg.sv
// Shared types and default sizing for the router ingress port.
// ROUTER_WIDTH is the flit width. The PORT_* values are the defaults for
// FIFO depth, downstream credits and counter width.
package router_ingress_port_pkg;

  localparam int ROUTER_WIDTH     = 32;
  localparam int PORT_FIFO_DEPTH  = 4;
  localparam int PORT_CREDIT_INIT = 4;
  localparam int PORT_CNT_WIDTH   = 3;

  typedef logic [ROUTER_WIDTH-1:0] flit_t;

  // Pointer width for a power-of-two circular buffer, never narrower than 1 bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/port_flit_fifo.sv
// Circular flit buffer for the router ingress port.
// A push into a full buffer is accepted only when a pop happens in the same
// cycle, because the pop frees the slot. Otherwise the flit is dropped and
// the pointers do not move. A pop of an empty buffer is ignored.
module port_flit_fifo
  import router_ingress_port_pkg::*;
#(
  parameter int DEPTH     = PORT_FIFO_DEPTH,
  parameter int CNT_WIDTH = PORT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  flit_t                push_data,
  input  logic                 pop,
  output flit_t                head_data,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 full,
  output logic                 empty
);

  localparam int PW = ptr_width(DEPTH);

  flit_t         mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          accept;
  logic          do_pop;

  assign full      = (count == CNT_WIDTH'(DEPTH));
  assign empty     = (count == '0);
  assign accept    = push && (!full || pop);
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  // Storage array: written on accepted pushes, not reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy. The pointers wrap naturally at a power-of-two depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({accept, do_pop})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/router_ingress_port.sv
// Credit-based ingress port between a PE network interface and the leaf router.
// Optional build macro: ROUTER_PORT_ERR_CHK_EN enables the sticky port_err
// protocol checker. When the macro is undefined, port_err is tied to 0.
//
// Flow control: in_data_valid is a push with no ready signal. The PE holds
// FIFO_DEPTH credits, and every upstream_credit pulse returns one of them when
// a flit leaves. A flit is forwarded (out_data_valid=1 for one cycle) only
// while credit_count is nonzero. Each downstream_credit pulse adds one credit,
// and the count saturates at CREDIT_INIT.
module router_ingress_port
  import router_ingress_port_pkg::*;
#(
  parameter int FIFO_DEPTH  = PORT_FIFO_DEPTH,
  parameter int CREDIT_INIT = PORT_CREDIT_INIT,
  parameter int CNT_WIDTH   = PORT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_data_valid,
  input  flit_t                in_data,
  output logic                 upstream_credit,
  output logic                 out_data_valid,
  output flit_t                out_data,
  input  logic                 downstream_credit,
  output logic [CNT_WIDTH-1:0] fifo_count,
  output logic [CNT_WIDTH-1:0] credit_count,
  output logic                 port_err
);

  localparam logic [CNT_WIDTH-1:0] CREDIT_MAX = CNT_WIDTH'(CREDIT_INIT);

  flit_t head_data;
  logic  fifo_full;
  logic  fifo_empty;
  logic  send;

  // A flit leaves whenever one is buffered and the next hop has room.
  assign send = !fifo_empty && (credit_count != '0);

  port_flit_fifo #(
    .DEPTH     (FIFO_DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_data_valid),
    .push_data (in_data),
    .pop       (send),
    .head_data (head_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Output stage: register the head on a send and pulse the PE credit with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data_valid  <= 1'b0;
      out_data        <= '0;
      upstream_credit <= 1'b0;
    end else begin
      out_data_valid  <= send;
      upstream_credit <= send;
      if (send) out_data <= head_data;
    end
  end

  // Downstream credit counter. A send and a returning credit in the same cycle cancel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_count <= CREDIT_MAX;
    end else begin
      case ({send, downstream_credit})
        2'b10:   credit_count <= credit_count - CNT_WIDTH'(1);
        2'b01:   if (credit_count != CREDIT_MAX) credit_count <= credit_count + CNT_WIDTH'(1);
        default: credit_count <= credit_count;
      endcase
    end
  end

`ifdef ROUTER_PORT_ERR_CHK_EN
  logic overflow_evt;
  logic credit_ovf_evt;

  assign overflow_evt   = in_data_valid && fifo_full && !send;
  assign credit_ovf_evt = downstream_credit && !send && (credit_count == CREDIT_MAX);

  // Sticky protocol error: overfilled FIFO or a surplus downstream credit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      port_err <= 1'b0;
    end else begin
      if (overflow_evt || credit_ovf_evt) port_err <= 1'b1;
`ifndef SYNTHESIS
      if (overflow_evt)   $error("router_ingress_port: push into full FIFO, flit dropped");
      if (credit_ovf_evt) $error("router_ingress_port: downstream credit beyond CREDIT_INIT");
`endif
    end
  end
`else
  assign port_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_ingress_port.sv
// Self-checking bench for router_ingress_port with the default sizing
// (FIFO depth 4, 4 downstream credits).
module tb_router_ingress_port;
  import router_ingress_port_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_data_valid;
  flit_t       in_data;
  logic        upstream_credit;
  logic        out_data_valid;
  flit_t       out_data;
  logic        downstream_credit;
  logic [2:0]  fifo_count;
  logic [2:0]  credit_count;
  logic        port_err;

  int total = 0;
  int bad   = 0;
  logic [ROUTER_WIDTH-1:0] exp_q[$];

  router_ingress_port dut (
    .clk               (clk),
    .rst               (rst),
    .in_data_valid     (in_data_valid),
    .in_data           (in_data),
    .upstream_credit   (upstream_credit),
    .out_data_valid    (out_data_valid),
    .out_data          (out_data),
    .downstream_credit (downstream_credit),
    .fifo_count        (fifo_count),
    .credit_count      (credit_count),
    .port_err          (port_err)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: inputs change at the negedge, outputs are sampled at the negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_flit(input logic [ROUTER_WIDTH-1:0] d, input bit expect_kept);
    in_data_valid = 1'b1;
    in_data       = d;
    if (expect_kept) exp_q.push_back(d);
  endtask

  task automatic idle_in();
    in_data_valid = 1'b0;
    in_data       = '0;
  endtask

  // Scoreboard monitor: every forwarded flit must match the head of exp_q.
  always @(negedge clk) begin
    logic [ROUTER_WIDTH-1:0] e;
    if (rst) begin
      total++;
      if (upstream_credit !== out_data_valid) begin
        bad++;
        $display("FAIL credit_pulse: upstream_credit=%0b out_data_valid=%0b", upstream_credit, out_data_valid);
      end
      if (out_data_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_flit: got %0h expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            bad++;
            $display("FAIL flit_data: got %0h expected %0h", out_data, e);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    downstream_credit = 1'b0;
    idle_in();
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_out_valid", out_data_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_up_credit", upstream_credit, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_credit_count", credit_count, 4);
    check("rst_port_err", port_err, 0);

    // Single flit latency: it is forwarded two edges after the push.
    push_flit(32'hA5, 1);
    step();
    idle_in();
    check("lat_valid_early", out_data_valid, 0);
    check("lat_fifo_1", fifo_count, 1);
    step();
    check("lat_valid", out_data_valid, 1);
    check("lat_data", out_data, 32'hA5);
    check("lat_up_credit", upstream_credit, 1);
    check("lat_credit_3", credit_count, 3);
    downstream_credit = 1'b1;
    step();
    downstream_credit = 1'b0;
    check("ret_credit_4", credit_count, 4);

    // Six flits with no returning credits: four go out, then the port stalls.
    for (int i = 0; i < 6; i++) begin
      push_flit(32'h10 + i, 1);
      step();
    end
    idle_in();
    step();
    step();
    check("stall_credit_0", credit_count, 0);
    check("stall_fifo_2", fifo_count, 2);
    check("stall_no_valid", out_data_valid, 0);
    downstream_credit = 1'b1;
    step();
    downstream_credit = 1'b0;
    check("one_credit", credit_count, 1);
    check("one_credit_no_send_yet", out_data_valid, 0);
    step();
    check("release_valid", out_data_valid, 1);
    check("release_credit_0", credit_count, 0);
    check("release_fifo_1", fifo_count, 1);
    step();
    step();
    check("release_only_one", out_data_valid, 0);
    check("release_fifo_hold", fifo_count, 1);
    // Drain and saturate the credit counter.
    downstream_credit = 1'b1;
    repeat (6) step();
    downstream_credit = 1'b0;
    check("sat_credit_4", credit_count, 4);
    check("drain_fifo_0", fifo_count, 0);
    check("drain_q_empty", exp_q.size(), 0);

    // Steady state: one flit per cycle while a credit returns every cycle.
    downstream_credit = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_flit(32'h20 + i, 1);
      step();
      if (i >= 1) check("steady_valid", out_data_valid, 1);
      check("steady_credit", credit_count, 4);
    end
    idle_in();
    step();
    check("steady_last_valid", out_data_valid, 1);
    check("steady_fifo_0", fifo_count, 0);
    downstream_credit = 1'b0;
    step();
    check("steady_end", out_data_valid, 0);
    check("steady_q_empty", exp_q.size(), 0);

    // Fill the FIFO with the credits used up.
    for (int i = 0; i < 8; i++) begin
      push_flit(32'h30 + i, 1);
      step();
    end
    idle_in();
    check("full_fifo_4", fifo_count, 4);
    check("full_credit_0", credit_count, 0);
    // A push to a full FIFO with no pop is dropped.
    push_flit(32'hDEAD, 0);
    step();
    idle_in();
    check("overflow_fifo_4", fifo_count, 4);
`ifdef ROUTER_PORT_ERR_CHK_EN
    check("overflow_port_err", port_err, 1);
`else
    check("overflow_port_err", port_err, 0);
`endif
    // One credit opens a send. From then on, push and pop happen together while full.
    downstream_credit = 1'b1;
    step();
    check("full_credit_1", credit_count, 1);
    for (int i = 0; i < 20; i++) begin
      push_flit($urandom_range(0, 32'hFFFF_FFFF), 1);
      step();
      check("full_pushpop_fifo", fifo_count, 4);
      check("full_pushpop_valid", out_data_valid, 1);
    end
    idle_in();
    downstream_credit = 1'b0;
    step();
    check("full_after_credit_0", credit_count, 0);
    check("full_after_fifo_3", fifo_count, 3);
    downstream_credit = 1'b1;
    repeat (8) step();
    downstream_credit = 1'b0;
    check("full_drain_fifo_0", fifo_count, 0);
    check("full_drain_credit_4", credit_count, 4);
    check("full_drain_q_empty", exp_q.size(), 0);

    // Reset in the middle of a burst while 3 flits are buffered.
    for (int i = 0; i < 7; i++) begin
      push_flit(32'h40 + i, 1);
      step();
    end
    idle_in();
    check("mid_fifo_3", fifo_count, 3);
    #2 rst = 1'b0;
    #1;
    exp_q.delete();
    check("async_fifo_0", fifo_count, 0);
    check("async_credit_4", credit_count, 4);
    check("async_valid_0", out_data_valid, 0);
    check("async_data_0", out_data, 0);
    check("async_up_credit_0", upstream_credit, 0);
    check("async_port_err_0", port_err, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    repeat (6) step();
    check("post_rst_fifo_0", fifo_count, 0);
    check("post_rst_credit_4", credit_count, 4);
    check("post_rst_no_valid", out_data_valid, 0);
    // Normal operation resumes after the reset.
    push_flit(32'h55, 1);
    step();
    idle_in();
    step();
    check("post_rst_flit", out_data_valid, 1);
    step();
    check("final_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
